mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the pipeline's instruction-fetch (IF) stage and the data-access (MEM) stage.
- Arbitrates their requests, tracks exactly one outstanding memory transaction, and routes the registered response back to its owner.
- Supports discarding an in-flight fetch on a branch redirect.
- Sits between the 5-stage core and the memory model; the core stalls IF or MEM until the matching rvalid arrives.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_prio.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/MEM memory port arbiter.
// Contents:
//   arb_state_e : arbiter FSM states (idle / waiting for memory response)
//   arb_owner_e : which requester owns the outstanding transaction
//   *_DEF       : default address/data widths and starvation limit
//   STARVE_CNT_W: width of the starvation counter (covers limits 1..15)
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STARVE_CNT_W     = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } arb_owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_prio.sv
// Priority select between the fetch (I) and data (D) requesters plus the
// starvation counter that bounds how long a pending fetch can lose to D.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   i_req, d_req  : raw requests from the two pipeline stages
//   gnt_i, gnt_d  : grant events actually taken this cycle (IDLE only)
//   sel_i, sel_d  : one-hot (or zero) winner of the current arbitration
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic gnt_i,
    input  logic gnt_d,
    output logic sel_i,
    output logic sel_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic                    force_i;

    // Winner select: D normally wins, I wins once D has had LIMIT grants in a row.
    always_comb begin
        force_i = (starve_cnt_q == LIMIT);
        sel_i   = i_req & (~d_req | force_i);
        sel_d   = d_req & ~sel_i;
    end

    // Starvation counter next value: only counts D grants while a fetch is waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req) begin
            starve_cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (gnt_i) begin
            starve_cnt_d = {STARVE_CNT_W{1'b0}};
        end else if (gnt_d && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= {STARVE_CNT_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule : mem_arb_prio

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM pipeline stages.
// Only one memory transaction is outstanding at a time; the registered
// response is routed back to whichever stage owns it. A fetch in flight can
// be discarded with i_kill (branch redirect).
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   i_req/i_addr/i_kill           : fetch request, address, discard in-flight fetch
//   i_gnt/i_rvalid/i_rdata        : fetch accepted, response pulse, instruction
//   d_req/d_we/d_be/d_addr/d_wdata: data request fields (store when d_we=1)
//   d_gnt/d_rvalid/d_rdata        : data accepted, response pulse, load data (0 for stores)
//   m_req/m_we/m_be/m_addr/m_wdata: request to memory (zero while waiting)
//   m_gnt/m_rvalid/m_rdata        : memory accept, response pulse, read data
// Optional build macro ARB_PERF_CNT_EN adds saturating performance counters
//   perf_conflict_cnt (IDLE cycles with both requests) and perf_drop_cnt
//   (fetch responses discarded by i_kill).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_kill,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_conflict_cnt,
    output logic [15:0]           perf_drop_cnt,
`endif
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              drop_q, drop_d;
    logic              store_q, store_d;     // owner D transaction is a store
    logic              i_rvalid_q, i_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              drop_evt;             // a fetch response is being discarded
    logic              sel_i, sel_d;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk   (clk),
        .rst   (rst),
        .i_req (i_req),
        .d_req (d_req),
        .gnt_i (i_gnt),
        .gnt_d (d_gnt),
        .sel_i (sel_i),
        .sel_d (sel_d)
    );

    // State register plus registered responses; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_NONE;
            drop_q     <= 1'b0;
            store_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= {DATA_W{1'b0}};
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            drop_q     <= drop_d;
            store_q    <= store_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic: grant latching, response capture and fetch discard.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        drop_d     = drop_q;
        store_d    = store_q;
        i_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rvalid_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        drop_evt   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (d_gnt) begin
                    state_d = ARB_WAIT;
                    owner_d = OWN_D;
                    store_d = d_we;
                    drop_d  = 1'b0;
                end else if (i_gnt) begin
                    state_d = ARB_WAIT;
                    owner_d = OWN_I;
                    store_d = 1'b0;
                    drop_d  = 1'b0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                    drop_d  = 1'b0;
                    store_d = 1'b0;
                    case (owner_q)
                        OWN_I: begin
                            // A kill arriving together with the response still discards it.
                            if (drop_q || i_kill) begin
                                drop_evt = 1'b1;
                            end else begin
                                i_rvalid_d = 1'b1;
                                i_rdata_d  = m_rdata;
                            end
                        end
                        OWN_D: begin
                            d_rvalid_d = 1'b1;
                            d_rdata_d  = store_q ? {DATA_W{1'b0}} : m_rdata;
                        end
                        default: begin
                            drop_evt = 1'b0;
                        end
                    endcase
                end else if ((owner_q == OWN_I) && i_kill) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
                drop_d  = 1'b0;
                store_d = 1'b0;
            end
        endcase
    end

    // Output logic: memory request mux and grants, only driven in IDLE.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_be    = {BE_W{1'b0}};
        m_addr  = {ADDR_W{1'b0}};
        m_wdata = {DATA_W{1'b0}};
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        if (state_q == ARB_IDLE) begin
            m_req = i_req | d_req;
            if (sel_d) begin
                m_we    = d_we;
                m_be    = d_be;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                d_gnt   = m_gnt;
            end else if (sel_i) begin
                m_we    = 1'b0;
                m_be    = {BE_W{1'b1}};
                m_addr  = i_addr;
                m_wdata = {DATA_W{1'b0}};
                i_gnt   = m_gnt;
            end else begin
                m_req = 1'b0;
            end
        end else begin
            m_req = 1'b0;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;
    logic [15:0] perf_drop_cnt_q, perf_drop_cnt_d;

    // Performance counter next values, both saturating.
    always_comb begin
        perf_conflict_cnt_d = perf_conflict_cnt_q;
        perf_drop_cnt_d     = perf_drop_cnt_q;
        if ((state_q == ARB_IDLE) && i_req && d_req && (perf_conflict_cnt_q != 32'hFFFF_FFFF)) begin
            perf_conflict_cnt_d = perf_conflict_cnt_q + 32'd1;
        end else begin
            perf_conflict_cnt_d = perf_conflict_cnt_q;
        end
        if (drop_evt && (perf_drop_cnt_q != 16'hFFFF)) begin
            perf_drop_cnt_d = perf_drop_cnt_q + 16'd1;
        end else begin
            perf_drop_cnt_d = perf_drop_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_cnt_q <= 32'd0;
            perf_drop_cnt_q     <= 16'd0;
        end else begin
            perf_conflict_cnt_q <= perf_conflict_cnt_d;
            perf_drop_cnt_q     <= perf_drop_cnt_d;
        end
    end

    assign perf_conflict_cnt = perf_conflict_cnt_q;
    assign perf_drop_cnt     = perf_drop_cnt_q;
`else
    // Without the counters the discard event only steers the response path.
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_kill;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_kill   (i_kill),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; i_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        tick(); tick();
        check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_m_req", 32'(m_req), 32'h0);
        check("rst_starve", 32'(dut.u_prio.starve_cnt_q), 32'h0);
        rst = 1'b1;
        tick();

        // Fetch only, response two cycles after grant
        i_req = 1'b1; i_addr = 32'h0; m_gnt = 1'b1;
        #1;
        check("f_m_req", 32'(m_req), 32'h1);
        check("f_i_gnt", 32'(i_gnt), 32'h1);
        check("f_d_gnt", 32'(d_gnt), 32'h0);
        check("f_m_be", 32'(m_be), 32'hF);
        check("f_m_we", 32'(m_we), 32'h0);
        tick();
        i_req = 1'b0;
        #1;
        check("f_wait_m_req", 32'(m_req), 32'h0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h00300093;
        check("f_no_early_rvalid", 32'(i_rvalid), 32'h0);
        tick();
        m_rvalid = 1'b0;
        check("f_i_rvalid", 32'(i_rvalid), 32'h1);
        check("f_i_rdata", i_rdata, 32'h00300093);
        check("f_d_rvalid", 32'(d_rvalid), 32'h0);
        tick();
        check("f_i_rvalid_pulse", 32'(i_rvalid), 32'h0);

        // Simultaneous requests: D load first, then I
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4;
        #1;
        check("s_d_gnt", 32'(d_gnt), 32'h1);
        check("s_i_gnt", 32'(i_gnt), 32'h0);
        check("s_m_addr", m_addr, 32'h4);
        tick();
        d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h000000ff;
        #1;
        check("s_wait_i_gnt", 32'(i_gnt), 32'h0);
        tick();
        m_rvalid = 1'b0;
        #1;
        check("s_d_rvalid", 32'(d_rvalid), 32'h1);
        check("s_d_rdata", d_rdata, 32'h000000ff);
        check("s_i_gnt_next", 32'(i_gnt), 32'h1);
        check("s_i_m_addr", m_addr, 32'h8);
        tick();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000011;
        check("s_d_rvalid_pulse", 32'(d_rvalid), 32'h0);
        tick();
        m_rvalid = 1'b0;
        check("s_i_rvalid", 32'(i_rvalid), 32'h1);
        check("s_i_rdata", i_rdata, 32'h00000011);
        tick();

        // Starvation: four D grants, then I is forced to win
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h44; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("st_d_gnt", 32'(d_gnt), 32'h1);
            check("st_i_gnt", 32'(i_gnt), 32'h0);
            tick();
            m_rvalid = 1'b1; m_rdata = 32'(k + 32'h100);
            tick();
            m_rvalid = 1'b0;
            check("st_d_rvalid", 32'(d_rvalid), 32'h1);
            check("st_d_rdata", d_rdata, 32'(k + 32'h100));
        end
        #1;
        check("st_cnt_sat", 32'(dut.u_prio.starve_cnt_q), 32'h4);
        check("st_5th_i_gnt", 32'(i_gnt), 32'h1);
        check("st_5th_d_gnt", 32'(d_gnt), 32'h0);
        check("st_5th_m_addr", m_addr, 32'h40);
        tick();
        i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
        check("st_cnt_clear", 32'(dut.u_prio.starve_cnt_q), 32'h0);
        tick();
        m_rvalid = 1'b0;
        check("st_i_rvalid", 32'(i_rvalid), 32'h1);
        check("st_i_rdata", i_rdata, 32'h55);
        check("st_d_rvalid", 32'(d_rvalid), 32'h0);
        tick();

        // Kill in WAIT drops the response
        i_req = 1'b1; i_addr = 32'h10;
        #1;
        check("k_i_gnt", 32'(i_gnt), 32'h1);
        tick();
        i_req = 1'b0; i_kill = 1'b1;
        tick();
        i_kill = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hdeadbeef;
        tick();
        m_rvalid = 1'b0;
        check("k_no_rvalid", 32'(i_rvalid), 32'h0);
        tick();
        check("k_no_rvalid2", 32'(i_rvalid), 32'h0);
        // Next fetch returns normally
        i_req = 1'b1; i_addr = 32'h14;
        #1;
        check("k_next_gnt", 32'(i_gnt), 32'h1);
        tick();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000013;
        tick();
        m_rvalid = 1'b0;
        check("k_next_rvalid", 32'(i_rvalid), 32'h1);
        check("k_next_rdata", i_rdata, 32'h00000013);
        tick();
        // Kill coinciding with the response
        i_req = 1'b1; i_addr = 32'h18;
        tick();
        i_req = 1'b0; i_kill = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0000cafe;
        tick();
        i_kill = 1'b0; m_rvalid = 1'b0;
        check("kc_no_rvalid", 32'(i_rvalid), 32'h0);
        check("kc_idle", 32'(dut.state_q), 32'h0);
        tick();

        // Store: fields forwarded, acknowledge returns zero data
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'h1234abcd;
        #1;
        check("w_d_gnt", 32'(d_gnt), 32'h1);
        check("w_m_we", 32'(m_we), 32'h1);
        check("w_m_be", 32'(m_be), 32'h3);
        check("w_m_wdata", m_wdata, 32'h1234abcd);
        check("w_m_addr", m_addr, 32'h20);
        tick();
        d_req = 1'b0; d_we = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hffffffff;
        tick();
        m_rvalid = 1'b0;
        check("w_d_rvalid", 32'(d_rvalid), 32'h1);
        check("w_d_rdata", d_rdata, 32'h0);
        tick();

        // Reset during WAIT, then a stale response
        i_req = 1'b1; i_addr = 32'h30;
        #1;
        check("r_i_gnt", 32'(i_gnt), 32'h1);
        tick();
        i_req = 1'b0; m_gnt = 1'b0; rst = 1'b0;
        #1;
        check("r_async_idle", 32'(dut.state_q), 32'h0);
        tick();
        rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h00000abc;
        tick();
        m_rvalid = 1'b0;
        check("r_i_rvalid", 32'(i_rvalid), 32'h0);
        check("r_d_rvalid", 32'(d_rvalid), 32'h0);
        check("r_i_rdata", i_rdata, 32'h0);
        check("r_d_rdata", d_rdata, 32'h0);
        check("r_m_req", 32'(m_req), 32'h0);
        check("r_state", 32'(dut.state_q), 32'h0);
        tick();
        check("r_i_rvalid2", 32'(i_rvalid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
